// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flow controller for the five-stage core.
// Generates stall/flush/hold controls for the pipeline registers:
// load-use stalls, branch-redirect bubbles and data-memory wait freezes.
// Also keeps saturating counters of stall cycles and accepted redirects.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]       BUBBLE_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;
    state_t     eff_state;
    logic [3:0] bcnt_q, bcnt_d;
    logic       redir_inc;
    logic       memwait;
    logic       loaduse;

    assign memwait = dmem_req & ~dmem_ready;
    assign loaduse = ex_MemRead & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));

    // MEM_WAIT is transparent once memory is ready: the saved state's rules
    // apply in that same cycle, so a branch frozen in EX is seen exactly once.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    assign state = state_q;

    // Next-state and control outputs, prioritised memwait > branch > bubble > load-use.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        redir_inc     = 1'b0;
        state_d       = state_q;
        saved_d       = saved_q;
        bcnt_d        = bcnt_q;
        if (reset) begin
            state_d = RUN;
        end else if (memwait) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
            saved_d       = eff_state;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            redir_inc   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                bcnt_d  = BUBBLE_LOAD;
                state_d = REDIRECT;
            end else begin
                state_d = RUN;
            end
        end else if (eff_state == REDIRECT) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (bcnt_q <= 4'd1) begin
                bcnt_d  = 4'd0;
                state_d = RUN;
            end else begin
                bcnt_d  = bcnt_q - 4'd1;
                state_d = REDIRECT;
            end
        end else begin
            state_d = RUN;
            if (loaduse) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    // State, bubble counter and saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            saved_q      <= RUN;
            bcnt_q       <= 4'd0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            bcnt_q  <= bcnt_d;
            if (pc_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (redir_inc && (redirect_cnt != '1))
                redirect_cnt <= redirect_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes hand-computed expectations
// per cycle into a queue, a monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

    localparam logic [6:0] C0  = 7'b0000000;
    localparam logic [6:0] CLU = 7'b1101000;
    localparam logic [6:0] CFL = 7'b0011000;
    localparam logic [6:0] CMW = 7'b1100111;
    localparam logic [1:0] SR  = 2'd0;
    localparam logic [1:0] SD  = 2'd1;
    localparam logic [1:0] SM  = 2'd2;

    typedef struct {
        int unsigned idx;
        logic        creg;
        logic [6:0]  ctrl;
        logic [1:0]  st;
        logic [31:0] sc;
        logic [31:0] rc;
        logic [6:0]  s_ctrl;
        logic [1:0]  s_st;
        logic [3:0]  s_sc;
        logic [3:0]  s_rc;
    } exp_t;

    exp_t q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_MemRead = 1'b0;
    logic ex_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic req_s = 1'b0, br_s = 1'b0;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic id_ex_hold, ex_mem_hold, mem_wb_bubble;
    logic [1:0]  state;
    logic [31:0] stall_cnt, redirect_cnt;

    logic s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_flush;
    logic s_id_ex_hold, s_ex_mem_hold, s_mem_wb_bubble;
    logic [1:0] s_state;
    logic [3:0] s_stall_cnt, s_redirect_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned step_no = 0;

    logic       creg_e = 1'b0;
    logic [6:0] s_ctrl_e = C0;
    logic [1:0] s_st_e = SR;
    logic [3:0] s_sc_e = 4'd0, s_rc_e = 4'd0;
    logic       nreq_s = 1'b0, nbr_s = 1'b0;

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .reset(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
        .mem_wb_bubble(mem_wb_bubble), .state(state),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_s (
        .clk(clk), .reset(rst),
        .id_rs1(5'd0), .id_rs2(5'd0),
        .id_uses_rs1(1'b0), .id_uses_rs2(1'b0),
        .ex_rd(5'd0), .ex_MemRead(1'b0),
        .ex_branch_taken(br_s),
        .dmem_req(req_s), .dmem_ready(1'b0),
        .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .id_ex_hold(s_id_ex_hold), .ex_mem_hold(s_ex_mem_hold),
        .mem_wb_bubble(s_mem_wb_bubble), .state(s_state),
        .stall_cnt(s_stall_cnt), .redirect_cnt(s_redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int unsigned idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("ctrl", e.idx, {25'd0, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
                                    id_ex_hold, ex_mem_hold, mem_wb_bubble}, {25'd0, e.ctrl});
                cmp("s_ctrl", e.idx, {25'd0, s_pc_stall, s_if_id_stall, s_if_id_flush,
                                      s_id_ex_flush, s_id_ex_hold, s_ex_mem_hold,
                                      s_mem_wb_bubble}, {25'd0, e.s_ctrl});
                if (e.creg) begin
                    cmp("state", e.idx, {30'd0, state}, {30'd0, e.st});
                    cmp("stall_cnt", e.idx, stall_cnt, e.sc);
                    cmp("redirect_cnt", e.idx, redirect_cnt, e.rc);
                    cmp("s_state", e.idx, {30'd0, s_state}, {30'd0, e.s_st});
                    cmp("s_stall_cnt", e.idx, {28'd0, s_stall_cnt}, {28'd0, e.s_sc});
                    cmp("s_redirect_cnt", e.idx, {28'd0, s_redirect_cnt}, {28'd0, e.s_rc});
                end
            end
        end
    end

    task automatic step(input logic r, input logic [4:0] erd, input logic mr,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic br,
                        input logic rq, input logic rd,
                        input logic [6:0] ec, input logic [1:0] es,
                        input int unsigned esc, input int unsigned erc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ex_rd = erd; ex_MemRead = mr; id_rs1 = r1; id_rs2 = r2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; ex_branch_taken = br;
        dmem_req = rq; dmem_ready = rd; req_s = nreq_s; br_s = nbr_s;
        e.idx = step_no; e.creg = creg_e; e.ctrl = ec; e.st = es;
        e.sc = esc; e.rc = erc; e.s_ctrl = s_ctrl_e; e.s_st = s_st_e;
        e.s_sc = s_sc_e; e.s_rc = s_rc_e;
        q.push_back(e);
        step_no++;
    endtask

    task automatic idle(input logic [6:0] ec, input logic [1:0] es,
                        input int unsigned esc, input int unsigned erc);
        step(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ec, es, esc, erc);
    endtask

    initial begin
        // reset: outputs forced low, then registered reset values
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, SR, 0, 0);
        creg_e = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, SR, 0, 0);
        idle(C0, SR, 0, 0);
        // load-use on rs2, then x0 load, rs1 unused, load-use on rs1
        step(0, 5, 1, 0, 5, 0, 1, 0, 0, 0, CLU, SR, 0, 0);
        idle(C0, SR, 1, 0);
        step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, C0, SR, 1, 0);
        step(0, 7, 1, 7, 3, 0, 1, 0, 0, 0, C0, SR, 1, 0);
        step(0, 7, 1, 7, 0, 1, 0, 0, 0, 0, CLU, SR, 1, 0);
        // load-use + branch: flush only, then two REDIRECT bubbles
        step(0, 5, 1, 0, 5, 0, 1, 1, 0, 0, CFL, SR, 2, 0);
        idle(CFL, SD, 2, 1);
        step(0, 5, 1, 0, 5, 0, 1, 0, 0, 0, CFL, SD, 2, 1);
        idle(C0, SR, 2, 1);
        // four-cycle memory wait
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CMW, SR, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CMW, SM, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CMW, SM, 4, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CMW, SM, 5, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C0, SM, 6, 1);
        idle(C0, SR, 6, 1);
        // memory wait in the middle of a redirect
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, CFL, SR, 6, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CMW, SD, 6, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CMW, SM, 7, 2);
        idle(CFL, SM, 8, 2);
        idle(CFL, SD, 8, 2);
        idle(C0, SR, 8, 2);
        // branch held through a two-cycle wait, then re-branch in REDIRECT
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, CMW, SR, 8, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, CMW, SM, 9, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, CFL, SM, 10, 2);
        idle(CFL, SD, 10, 3);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, CFL, SD, 10, 3);
        idle(CFL, SD, 10, 4);
        idle(CFL, SD, 10, 4);
        idle(C0, SR, 10, 4);
        // reset while in REDIRECT with every hazard input active
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, CFL, SR, 10, 4);
        step(1, 5, 1, 5, 0, 1, 0, 1, 1, 0, C0, SD, 10, 5);
        idle(C0, SR, 0, 0);
        // saturation of the 4-bit stall counter over 20 wait cycles
        nreq_s = 1'b1;
        s_ctrl_e = CMW;
        for (int k = 0; k < 20; k++) begin
            s_st_e = (k == 0) ? SR : SM;
            s_sc_e = (k > 15) ? 4'd15 : 4'(k);
            idle(C0, SR, 0, 0);
        end
        nreq_s = 1'b0; s_ctrl_e = C0; s_st_e = SM; s_sc_e = 4'd15;
        idle(C0, SR, 0, 0);
        // single-cycle flush with FLUSH_CYCLES=1 stays in RUN
        nbr_s = 1'b1; s_ctrl_e = CFL; s_st_e = SR;
        idle(C0, SR, 0, 0);
        nbr_s = 1'b0; s_ctrl_e = C0; s_rc_e = 4'd1;
        idle(C0, SR, 0, 0);
        idle(C0, SR, 0, 0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
